tt_um_bitwise_sequencer: RTL

- Command-driven controller that sequences a bitwise operator unit over a Tiny Tapeout pin interface.
- Host loads operand A and operand B, then issues an execute command with an opcode.
- Block evaluates the operation bit-serially, LSB first, over 8 cycles, then presents the result with status flags.
- Standalone user-project top; replaces a purely combinational operator with a host-sequenced one.

---
 rtl/bitseq_pkg.sv | 40 ++++
 rtl/bitseq_if.sv | 11 +
 rtl/bitseq_strobe_sync.sv | 26 ++
 rtl/tt_um_bitwise_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bitseq_pkg.sv
// Shared types and constants for the bit-serial bitwise sequencer.
package bitseq_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    CMD_LOAD_A = 2'b00,
    CMD_LOAD_B = 2'b01,
    CMD_EXEC   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    OP_OR     = 3'b000,
    OP_AND    = 3'b001,
    OP_XOR    = 3'b010,
    OP_NAND   = 3'b011,
    OP_NOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_MIX    = 3'b110,
    OP_PASS_A = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int UIO_STRB    = 0;
  localparam int UIO_CMD_LSB = 1;
  localparam int UIO_ACC     = 3;
  localparam int UIO_ERR     = 5;
  localparam int UIO_BUSY    = 6;
  localparam int UIO_DONE    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hE0;

endpackage

// File: rtl/bitseq_if.sv
// Tiny Tapeout pin bundle between a host and the sequencer.
interface bitseq_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in, input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in, output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/bitseq_strobe_sync.sv
// Synchronizes the asynchronous host strobe and emits one accept pulse per rising edge.
module bitseq_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strb,
  output logic accept
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      accept <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strb};
      prev_q <= sync_q[SYNC_STAGES-1];
      accept <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/tt_um_bitwise_sequencer.sv
// Host-sequenced bit-serial bitwise operator (LSB first, 8 cycles per EXEC).
// Optional macro BITSEQ_ACCUM_EN: EXEC with acc=1 also writes its result back into A.
module tt_um_bitwise_sequencer
  import bitseq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  function automatic logic eval_bit(op_e f, logic x, logic y, logic msb);
    case (f)
      OP_OR:     return x | y;
      OP_AND:    return x & y;
      OP_XOR:    return x ^ y;
      OP_NAND:   return ~(x & y);
      OP_NOR:    return ~(x | y);
      OP_XNOR:   return ~(x ^ y);
      OP_MIX:    return msb ? (x ^ y) : (x | y);
      OP_PASS_A: return x;
      default:   return x;
    endcase
  endfunction

  logic             accept;
  state_e           state;
  logic [WIDTH-1:0] a, b, work, result;
  op_e              op;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             busy, done, err;
  cmd_e             cmd;
  logic             bit_res;
  logic [WIDTH-1:0] next_work;

  bitseq_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strb   (uio_in[UIO_STRB]),
    .accept (accept)
  );

  assign cmd       = cmd_e'(uio_in[UIO_CMD_LSB +: 2]);
  assign bit_res   = eval_bit(op, a[cnt], b[cnt], cnt == CNT_W'(WIDTH-1));
  // Results enter from the MSB so bit i lands at position i after WIDTH shifts.
  assign next_work = {bit_res, work[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      work   <= '0;
      result <= '0;
      op     <= OP_OR;
      acc    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (accept && cmd == CMD_CLEAR) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (state == ST_EXEC) begin
      // Commands other than CLEAR arriving mid-operation are dropped but flagged.
      if (accept) err <= 1'b1;
      work <= next_work;
      cnt  <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH-1)) begin
        result <= next_work;
        busy   <= 1'b0;
        done   <= 1'b1;
        state  <= ST_DONE;
`ifdef BITSEQ_ACCUM_EN
        if (acc) a <= next_work;
`endif
      end
    end else if (accept) begin
      done <= 1'b0;
      case (cmd)
        CMD_LOAD_A: begin
          a     <= ui_in;
          state <= ST_IDLE;
        end
        CMD_LOAD_B: begin
          b     <= ui_in;
          state <= ST_IDLE;
        end
        CMD_EXEC: begin
          op    <= op_e'(ui_in[2:0]);
          acc   <= uio_in[UIO_ACC];
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ST_EXEC;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uio_out           = '0;
    uio_out[UIO_DONE] = done;
    uio_out[UIO_BUSY] = busy;
    uio_out[UIO_ERR]  = err;
  end

  assign uo_out = result;
  assign uio_oe = UIO_OE_MASK;

  logic unused_pins;
`ifdef BITSEQ_ACCUM_EN
  assign unused_pins = &{1'b0, ena, uio_in[7:4], work[0]};
`else
  assign unused_pins = &{1'b0, ena, uio_in[7:4], work[0], acc};
`endif

endmodule
